// File: rtl/rs232_pkg.sv
// -----------------------------------------------------------------------------
// rs232_pkg
// Shared definitions for the RS-232 tap: playback record layout, opcodes,
// FSM state encodings and the bit positions of the 16 tap lines.
// The capture path uses the same line-bit constants, so line words coming back
// from the host can be replayed exactly as they were captured.
// -----------------------------------------------------------------------------
package rs232_pkg;

   // A playback record is fixed at 8 bytes; the host tool depends on this size.
   localparam int REC_BYTES = 8;
   localparam int REC_BITS  = REC_BYTES * 8;

   // Byte offsets inside a record (big-endian, byte 0 arrives first).
   localparam int OFS_OPCODE = 0;
   localparam int OFS_DELAY  = 1;
   localparam int OFS_RSVD   = 5;
   localparam int OFS_LINES  = 6;

   localparam logic [7:0] OPC_DRIVE = 8'h00;

   // Record as it sits in the shift register: byte 0 ends up in the MSBs.
   typedef struct packed {
      logic [7:0]  opcode;
      logic [31:0] delay;
      logic [7:0]  rsvd;
      logic [15:0] lines;
   } play_rec_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_WAIT     = 3'd2,
      ST_APPLY    = 3'd3,
      ST_ARM      = 3'd4,
      ST_ARM_WAIT = 3'd5
   } play_state_e;

   // Bit positions of the tap lines inside a 16-bit line word.
   localparam int LINE_A_RTS = 15;
   localparam int LINE_A_TXD = 14;
   localparam int LINE_A_DTR = 13;
   localparam int LINE_B_CD  = 12;
   localparam int LINE_B_DSR = 11;
   localparam int LINE_B_RXD = 10;
   localparam int LINE_B_CTS = 9;
   localparam int LINE_B_RI  = 8;
   localparam int LINE_C_RTS = 7;
   localparam int LINE_C_TXD = 6;
   localparam int LINE_C_DTR = 5;
   localparam int LINE_D_CD  = 4;
   localparam int LINE_D_DSR = 3;
   localparam int LINE_D_RXD = 2;
   localparam int LINE_D_CTS = 1;
   localparam int LINE_D_RI  = 0;

endpackage

// File: rtl/rs232_sync2.sv
// -----------------------------------------------------------------------------
// rs232_sync2
// Two-flop synchronizer for single-bit level signals arriving from the ULPI
// clock domain.
// Ports:
//   clk_50  - destination clock
//   reset   - asynchronous, active-high reset (output reads 0)
//   d       - asynchronous input level
//   q       - synchronized level, two clk_50 edges behind d
// -----------------------------------------------------------------------------
module rs232_sync2 (
   input  logic clk_50,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // First stage may go metastable; only the second stage is used downstream.
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/rs232_playback.sv
// -----------------------------------------------------------------------------
// rs232_playback
// Host-to-device playback engine. Drains 8-byte records from the USB OUT
// endpoint buffer and drives the 16 RS-232 tap lines at scheduled times.
// Each record is {opcode, delay[31:0], reserved, line_word[15:0]}; opcode
// 0x00 drives line_word onto line_out, any other opcode is skipped.
//
// Build option:
//   RS232_PLAY_ABSTIME_EN - delay field is an absolute timestamp compared
//                           against a free-running tick counter instead of a
//                           relative countdown.
//
// Ports:
//   clk_50           - system clock
//   reset            - asynchronous, active-high reset
//   play_en          - playback enable; dropping it mid-record aborts
//   buf_out_addr     - OUT buffer byte address
//   buf_out_q        - OUT buffer read data, READ_LAT clocks after address
//   buf_out_len      - valid byte count of the filled buffer
//   buf_out_hasdata  - buffer filled (ULPI domain, synchronized here)
//   buf_out_arm      - release buffer back to the USB core
//   buf_out_arm_ack  - release acknowledge (ULPI domain, synchronized here)
//   line_out         - tap line word, IDLE_LINES when not playing
//   active           - playback owns the RS-232 pins
//   err_len          - sticky: a buffer length was not a multiple of 8
//   rec_count        - number of DRIVE records applied since reset (wraps)
// -----------------------------------------------------------------------------
module rs232_playback
   import rs232_pkg::*;
#(
   parameter logic [15:0] IDLE_LINES = 16'hFFFF,
   parameter int          READ_LAT   = 2
) (
   input  logic        clk_50,
   input  logic        reset,
   input  logic        play_en,
   output logic [8:0]  buf_out_addr,
   input  logic [7:0]  buf_out_q,
   input  logic [9:0]  buf_out_len,
   input  logic        buf_out_hasdata,
   output logic        buf_out_arm,
   input  logic        buf_out_arm_ack,
   output logic [15:0] line_out,
   output logic        active,
   output logic        err_len,
   output logic [15:0] rec_count
);

   // Fetch lasts REC_BYTES address cycles plus READ_LAT cycles of read latency.
   localparam int FCNT_W = $clog2(REC_BYTES + READ_LAT);
   localparam logic [FCNT_W-1:0] FETCH_LAST = FCNT_W'(REC_BYTES + READ_LAT - 1);
   localparam logic [FCNT_W-1:0] BYTE_LAST  = FCNT_W'(REC_BYTES - 1);
   localparam logic [FCNT_W-1:0] READ_LAT_C = FCNT_W'(READ_LAT);

   logic hasdata_s;
   logic arm_ack_s;

   play_state_e       state_q,     state_d;
   logic [15:0]       line_q,      line_d;
   logic              active_q,    active_d;
   logic [8:0]        addr_q,      addr_d;
   logic              arm_q,       arm_d;
   logic              err_len_q,   err_len_d;
   logic [15:0]       rec_count_q, rec_count_d;
   logic [6:0]        nrec_q,      nrec_d;
   logic [6:0]        rec_idx_q,   rec_idx_d;
   logic [FCNT_W-1:0] fcnt_q,      fcnt_d;
   play_rec_t         rec_q,       rec_d;
`ifdef RS232_PLAY_ABSTIME_EN
   logic [31:0]       tick_q,      tick_d;
`else
   logic [31:0]       dly_q,       dly_d;
`endif

   logic abort;

   rs232_sync2 u_sync_hasdata (
      .clk_50 (clk_50),
      .reset  (reset),
      .d      (buf_out_hasdata),
      .q      (hasdata_s)
   );

   rs232_sync2 u_sync_arm_ack (
      .clk_50 (clk_50),
      .reset  (reset),
      .d      (buf_out_arm_ack),
      .q      (arm_ack_s)
   );

   // Losing play_en while a record is in flight throws the rest of the buffer
   // away; the ARM handshake still runs so the USB core gets its buffer back.
   assign abort = !play_en &&
                  (state_q == ST_FETCH || state_q == ST_WAIT || state_q == ST_APPLY);

   // Next-state and next-output logic for the playback FSM. Every register
   // holds by default; the abort override at the end has the final say.
   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      active_d    = active_q;
      addr_d      = addr_q;
      arm_d       = arm_q;
      err_len_d   = err_len_q;
      rec_count_d = rec_count_q;
      nrec_d      = nrec_q;
      rec_idx_d   = rec_idx_q;
      fcnt_d      = fcnt_q;
      rec_d       = rec_q;
`ifdef RS232_PLAY_ABSTIME_EN
      tick_d      = tick_q + 32'd1;
`else
      dly_d       = dly_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            // Lines are only handed back to passthrough once play_en falls,
            // so the last driven word survives the gap between buffers.
            if (!play_en) begin
               active_d = 1'b0;
            end
            if (play_en && hasdata_s) begin
               nrec_d    = buf_out_len[9:3];
               rec_idx_d = '0;
               if (buf_out_len[2:0] != 3'd0) begin
                  err_len_d = 1'b1;
               end
               if (buf_out_len[9:3] == 7'd0) begin
                  state_d = ST_ARM;
                  arm_d   = 1'b1;
               end else begin
                  state_d  = ST_FETCH;
                  active_d = 1'b1;
                  addr_d   = '0;
                  fcnt_d   = '0;
`ifdef RS232_PLAY_ABSTIME_EN
                  // Timestamps of a fresh session count from its first fetch.
                  if (!active_q) begin
                     tick_d = '0;
                  end
`endif
               end
            end
         end

         ST_FETCH: begin
            // Addresses run for the first REC_BYTES cycles; bytes are shifted
            // in READ_LAT cycles behind their address.
            if (fcnt_q < BYTE_LAST) begin
               addr_d = addr_q + 9'd1;
            end
            if (fcnt_q >= READ_LAT_C) begin
               rec_d = play_rec_t'({rec_q[REC_BITS-9:0], buf_out_q});
            end
            if (fcnt_q == FETCH_LAST) begin
               state_d = ST_WAIT;
`ifndef RS232_PLAY_ABSTIME_EN
               dly_d   = rec_d.delay;
`endif
            end else begin
               fcnt_d = fcnt_q + 1'b1;
            end
         end

         ST_WAIT: begin
`ifdef RS232_PLAY_ABSTIME_EN
            if (tick_q >= rec_q.delay) begin
               state_d = ST_APPLY;
            end
`else
            if (dly_q == 32'd0) begin
               state_d = ST_APPLY;
            end else begin
               dly_d = dly_q - 32'd1;
            end
`endif
         end

         ST_APPLY: begin
            if (rec_q.opcode == OPC_DRIVE) begin
               line_d      = rec_q.lines;
               rec_count_d = rec_count_q + 16'd1;
            end
            rec_idx_d = rec_idx_q + 7'd1;
            if (rec_idx_d == nrec_q) begin
               state_d = ST_ARM;
               arm_d   = 1'b1;
            end else begin
               state_d = ST_FETCH;
               addr_d  = {rec_idx_d[5:0], 3'b000};
               fcnt_d  = '0;
            end
         end

         ST_ARM: begin
            if (arm_ack_s) begin
               state_d = ST_ARM_WAIT;
               arm_d   = 1'b0;
            end
         end

         ST_ARM_WAIT: begin
            // Wait for the ack to clear so a stale ack cannot release the
            // next buffer; hasdata is not looked at until back in IDLE.
            if (!arm_ack_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            arm_d   = 1'b0;
         end
      endcase

      if (abort) begin
         state_d     = ST_ARM;
         arm_d       = 1'b1;
         line_d      = IDLE_LINES;
         active_d    = 1'b0;
         rec_count_d = rec_count_q;
      end
   end

   // State and registered outputs. Reset is asynchronous so buf_out_arm and
   // the tap lines let go immediately, without waiting for a clock edge.
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         line_q      <= IDLE_LINES;
         active_q    <= 1'b0;
         addr_q      <= '0;
         arm_q       <= 1'b0;
         err_len_q   <= 1'b0;
         rec_count_q <= '0;
         nrec_q      <= '0;
         rec_idx_q   <= '0;
         fcnt_q      <= '0;
         rec_q       <= '0;
`ifdef RS232_PLAY_ABSTIME_EN
         tick_q      <= '0;
`else
         dly_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         active_q    <= active_d;
         addr_q      <= addr_d;
         arm_q       <= arm_d;
         err_len_q   <= err_len_d;
         rec_count_q <= rec_count_d;
         nrec_q      <= nrec_d;
         rec_idx_q   <= rec_idx_d;
         fcnt_q      <= fcnt_d;
         rec_q       <= rec_d;
`ifdef RS232_PLAY_ABSTIME_EN
         tick_q      <= tick_d;
`else
         dly_q       <= dly_d;
`endif
      end
   end

   assign buf_out_addr = addr_q;
   assign buf_out_arm  = arm_q;
   assign line_out     = line_q;
   assign active       = active_q;
   assign err_len      = err_len_q;
   assign rec_count    = rec_count_q;

endmodule

// File: tb/tb_rs232_playback.sv
// -----------------------------------------------------------------------------
// tb_rs232_playback
// Directed bench for rs232_playback (relative-delay build). A small OUT buffer
// model answers reads two clocks after the address. Each buffer handed to the
// DUT pushes its expected line words and the clk_50 edge on which each should
// appear; every line_out change pops and compares against that scoreboard.
// -----------------------------------------------------------------------------
module tb_rs232_playback;

   // Edges from raising hasdata to the first FETCH cycle: two synchronizer
   // flops plus the IDLE decision.
   localparam int SYNC_LAT     = 3;
   // Eight address cycles plus two cycles of buffer read latency.
   localparam int FETCH_CYCLES = 10;
   // The countdown hits zero `delay` ticks after WAIT entry; one more cycle to
   // leave WAIT, then APPLY registers the word on the following edge.
   localparam int APPLY_LAT    = 2;

   logic        clk50 = 1'b0;
   logic        reset;
   logic        playEn;
   logic [8:0]  bufOutAddr;
   logic [7:0]  bufOutQ;
   logic [9:0]  bufOutLen;
   logic        bufOutHasdata;
   logic        bufOutArm;
   logic        bufOutArmAck;
   logic [15:0] lineOut;
   logic        active;
   logic        errLen;
   logic [15:0] recCount;

   logic [7:0]  mem [0:511];
   logic [7:0]  rdStage;

   typedef struct {
      logic [15:0] word;
      int          cycle;
   } expT;

   expT         expQ [$];
   int          cyc        = 0;
   int          checkCount = 0;
   int          passCount  = 0;
   int          failCount  = 0;
   int          expCount   = 0;
   logic [15:0] lastLine;

   logic [7:0]  recOpc  [4];
   logic [31:0] recDly  [4];
   logic [15:0] recWord [4];

   rs232_playback dut (
      .clk_50          (clk50),
      .reset           (reset),
      .play_en         (playEn),
      .buf_out_addr    (bufOutAddr),
      .buf_out_q       (bufOutQ),
      .buf_out_len     (bufOutLen),
      .buf_out_hasdata (bufOutHasdata),
      .buf_out_arm     (bufOutArm),
      .buf_out_arm_ack (bufOutArmAck),
      .line_out        (lineOut),
      .active          (active),
      .err_len         (errLen),
      .rec_count       (recCount)
   );

   always #5 clk50 = ~clk50;

   // Edge counter: at each negedge it equals the number of rising edges seen.
   always @(posedge clk50) cyc <= cyc + 1;

   // OUT buffer: data appears two clocks after the address changes.
   always @(posedge clk50) begin
      rdStage <= mem[bufOutAddr];
      bufOutQ <= rdStage;
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic setRec(input int idx, input logic [7:0] opc,
                         input logic [31:0] dly, input logic [15:0] word);
      recOpc[idx]  = opc;
      recDly[idx]  = dly;
      recWord[idx] = word;
   endtask

   // Loads nRecs records into the buffer, predicts when each DRIVE record
   // lands on line_out, then hands the buffer over with length len.
   task automatic applyStimulus(input int len, input int nRecs);
      int t;
      @(negedge clk50);
      for (int r = 0; r < nRecs; r++) begin
         mem[r*8+0] = recOpc[r];
         mem[r*8+1] = recDly[r][31:24];
         mem[r*8+2] = recDly[r][23:16];
         mem[r*8+3] = recDly[r][15:8];
         mem[r*8+4] = recDly[r][7:0];
         mem[r*8+5] = 8'h00;
         mem[r*8+6] = recWord[r][15:8];
         mem[r*8+7] = recWord[r][7:0];
      end
      t = cyc + SYNC_LAT;
      for (int r = 0; r < len / 8; r++) begin
         t = t + FETCH_CYCLES + int'(recDly[r]) + APPLY_LAT;
         if (recOpc[r] == 8'h00) begin
            expQ.push_back('{recWord[r], t});
            expCount++;
         end
      end
      bufOutLen     = 10'(len);
      bufOutHasdata = 1'b1;
   endtask

   // Waits for the next line_out change and checks it against the scoreboard.
   task automatic checkLineChange(input string tag, input int maxCycles);
      bit  seen = 1'b0;
      expT e;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk50);
         if (lineOut !== lastLine) seen = 1'b1;
      end
      checkOutput({tag, " change seen"}, 32'(seen), 32'(1));
      if (!seen) return;
      lastLine = lineOut;
      checkOutput({tag, " scoreboard entry pending"}, 32'(expQ.size() > 0), 32'(1));
      if (expQ.size() == 0) return;
      e = expQ.pop_front();
      checkOutput({tag, " word"}, 32'(lineOut), 32'(e.word));
      checkOutput({tag, " cycle"}, 32'(cyc), 32'(e.cycle));
   endtask

   task automatic waitArm(input string tag, input int maxCycles);
      bit seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk50);
         if (bufOutArm === 1'b1) seen = 1'b1;
      end
      checkOutput({tag, " arm raised"}, 32'(seen), 32'(1));
   endtask

   // Host side of the buffer release: drop hasdata, ack, wait for arm to
   // fall, then drop the ack and give the DUT time to get back to IDLE.
   task automatic releaseArm(input string tag);
      bit seen = 1'b0;
      bufOutHasdata = 1'b0;
      bufOutArmAck  = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk50);
         if (bufOutArm === 1'b0) seen = 1'b1;
      end
      checkOutput({tag, " arm released"}, 32'(seen), 32'(1));
      bufOutArmAck = 1'b0;
      repeat (6) @(negedge clk50);
   endtask

   initial begin
      reset         = 1'b1;
      playEn        = 1'b0;
      bufOutLen     = '0;
      bufOutHasdata = 1'b0;
      bufOutArmAck  = 1'b0;
      lastLine      = 16'hFFFF;
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;

      // Reset state
      repeat (3) @(negedge clk50);
      checkOutput("reset line_out", 32'(lineOut), 32'hFFFF);
      checkOutput("reset active", 32'(active), 32'(0));
      checkOutput("reset addr", 32'(bufOutAddr), 32'(0));
      checkOutput("reset arm", 32'(bufOutArm), 32'(0));
      checkOutput("reset err_len", 32'(errLen), 32'(0));
      checkOutput("reset rec_count", 32'(recCount), 32'(0));
      reset  = 1'b0;
      playEn = 1'b1;
      repeat (2) @(negedge clk50);

      $display("[TB] single record, delay 16");
      setRec(0, 8'h00, 32'd16, 16'hA5C3);
      applyStimulus(8, 1);
      checkLineChange("single", 200);
      checkOutput("single rec_count", 32'(recCount), 32'(expCount));
      checkOutput("single active", 32'(active), 32'(1));
      waitArm("single", 50);
      releaseArm("single");
      checkOutput("active held between buffers", 32'(active), 32'(1));

      $display("[TB] three records, delays 0/5/0");
      setRec(0, 8'h00, 32'd0, 16'h0001);
      setRec(1, 8'h00, 32'd5, 16'h0002);
      setRec(2, 8'h00, 32'd0, 16'h0003);
      applyStimulus(24, 3);
      checkLineChange("three rec0", 100);
      checkLineChange("three rec1", 100);
      checkLineChange("three rec2", 100);
      checkOutput("three rec_count", 32'(recCount), 32'(expCount));
      checkOutput("three err_len", 32'(errLen), 32'(0));
      waitArm("three", 50);
      releaseArm("three");

      $display("[TB] length 13");
      setRec(0, 8'h00, 32'd2, 16'h5A5A);
      setRec(1, 8'h00, 32'd0, 16'hDEAD);
      applyStimulus(13, 2);
      checkLineChange("len13", 100);
      checkOutput("len13 err_len", 32'(errLen), 32'(1));
      checkOutput("len13 rec_count", 32'(recCount), 32'(expCount));
      waitArm("len13", 50);
      releaseArm("len13");

      $display("[TB] length 0");
      applyStimulus(0, 0);
      waitArm("len0", 50);
      releaseArm("len0");
      checkOutput("len0 line_out", 32'(lineOut), 32'h5A5A);
      checkOutput("len0 err_len", 32'(errLen), 32'(1));
      checkOutput("len0 rec_count", 32'(recCount), 32'(expCount));

      $display("[TB] skip opcode 0x7F");
      setRec(0, 8'h7F, 32'd3, 16'h1234);
      applyStimulus(8, 1);
      waitArm("skip", 100);
      checkOutput("skip line_out", 32'(lineOut), 32'h5A5A);
      checkOutput("skip rec_count", 32'(recCount), 32'(expCount));
      checkOutput("skip scoreboard empty", 32'(expQ.size()), 32'(0));
      releaseArm("skip");

      $display("[TB] abort during long wait");
      setRec(0, 8'h00, 32'd1000, 16'hBEEF);
      applyStimulus(8, 1);
      repeat (SYNC_LAT + FETCH_CYCLES + 400) @(negedge clk50);
      playEn = 1'b0;
      // The pending record is discarded; the idle word shows up next edge.
      void'(expQ.pop_back());
      expCount--;
      expQ.push_back('{16'hFFFF, cyc + 1});
      checkLineChange("abort", 5);
      checkOutput("abort active", 32'(active), 32'(0));
      checkOutput("abort rec_count", 32'(recCount), 32'(expCount));
      waitArm("abort", 10);
      releaseArm("abort");

      $display("[TB] async reset while armed");
      playEn = 1'b1;
      setRec(0, 8'h00, 32'd0, 16'h1111);
      applyStimulus(8, 1);
      checkLineChange("pre-reset", 100);
      waitArm("pre-reset", 50);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async reset arm", 32'(bufOutArm), 32'(0));
      checkOutput("async reset line_out", 32'(lineOut), 32'hFFFF);
      checkOutput("async reset active", 32'(active), 32'(0));
      checkOutput("async reset addr", 32'(bufOutAddr), 32'(0));
      checkOutput("async reset err_len", 32'(errLen), 32'(0));
      checkOutput("async reset rec_count", 32'(recCount), 32'(0));
      bufOutHasdata = 1'b0;
      @(negedge clk50);
      reset = 1'b0;
      repeat (3) @(negedge clk50);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
